// File: rtl/disp_hex_mux_gen_pkg.sv
// Shared constants for the seven-segment display drivers: segment patterns,
// blank/off values and the active-low polarity of the board pins.
package disp_pkg;

    localparam logic AN_ON  = 1'b0;
    localparam logic SEG_ON = 1'b0;
    localparam logic DP_ON  = 1'b0;

    localparam logic [7:0] SSEG_OFF  = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/disp_hex_mux_gen_if.sv
// Data/load side and pin side of the multiplexed hex display driver.
interface disp_hex_mux_gen_if #(
    parameter int N_DIG = 4
) ();

    logic                 load;
    logic [4*N_DIG-1:0]   hex_in;
    logic [N_DIG-1:0]     dp_in;
    logic                 blank_lz;
    logic [3:0]           bright;
    logic [N_DIG-1:0]     an;
    logic [7:0]           sseg;

    modport master (
        output load, hex_in, dp_in, blank_lz, bright,
        input  an, sseg
    );

    modport slave (
        input  load, hex_in, dp_in, blank_lz, bright,
        output an, sseg
    );

endinterface

// File: rtl/disp_hex_mux_gen_hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment {g..a} decoder.
module hex_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/disp_hex_mux_gen.sv
// Time-multiplexed N_DIG-digit hex display driver with leading-zero blanking.
// Define DISP_HEX_MUX_PWM_EN to add per-digit PWM brightness control.
module disp_hex_mux_gen
    import disp_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int CNT_W = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    disp_hex_mux_gen_if.slave bus
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [CNT_W-1:0]   q;
    logic [IDX_W-1:0]   idx;
    logic [4*N_DIG-1:0] shadow_hex;
    logic [N_DIG-1:0]   shadow_dp;
    logic [3:0]         nib;
    logic [6:0]         seg;
    logic [N_DIG-1:0]   upper_zero;
    logic               blank;
    logic               enable;
    logic [N_DIG-1:0]   an_next, an_r;
    logic [7:0]         sseg_next, sseg_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= '0;
            idx <= '0;
        end else begin
            q <= q + 1'b1;
            if (&q)
                idx <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_hex <= '0;
            shadow_dp  <= '0;
        end else if (bus.load) begin
            shadow_hex <= bus.hex_in;
            shadow_dp  <= bus.dp_in;
        end
    end

    assign nib = shadow_hex[{idx, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .hex (nib),
        .seg (seg)
    );

    // upper_zero[k]: every nibble from the top digit down to k is zero
    always_comb begin
        upper_zero = '0;
        upper_zero[N_DIG-1] = (shadow_hex[4*(N_DIG-1) +: 4] == 4'h0);
        for (int k = N_DIG - 2; k >= 0; k--)
            upper_zero[k] = upper_zero[k+1] && (shadow_hex[4*k +: 4] == 4'h0);
    end

    assign blank = bus.blank_lz && (idx != '0) && upper_zero[idx];

`ifdef DISP_HEX_MUX_PWM_EN
    assign enable = (q[CNT_W-1 -: 4] <= bus.bright);
`else
    logic unused_bright;
    assign unused_bright = ^bus.bright;
    assign enable = 1'b1;
`endif

    always_comb begin
        an_next   = {N_DIG{~AN_ON}};
        sseg_next = SSEG_OFF;
        if (enable) begin
            an_next[idx] = AN_ON;
            sseg_next    = {shadow_dp[idx] ? DP_ON : ~DP_ON, blank ? SEG_BLANK : seg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r   <= {N_DIG{~AN_ON}};
            sseg_r <= SSEG_OFF;
        end else begin
            an_r   <= an_next;
            sseg_r <= sseg_next;
        end
    end

    assign bus.an   = an_r;
    assign bus.sseg = sseg_r;

endmodule

// File: tb/tb_disp_hex_mux_gen.sv
// Testbench for disp_hex_mux_gen: cycle scoreboard plus directed digit checks.
module tb_disp_hex_mux_gen;

    localparam int N_DIG = 4;
    localparam int CNT_W = 4;
`ifdef DISP_HEX_MUX_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   testsRun = 0;
    int   testsFailed = 0;

    exp_t expQ[$];
    logic [CNT_W-1:0] mQ;
    logic [1:0]       mIdx;
    logic [15:0]      mHex;
    logic [3:0]       mDp;

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] scanOrder [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    always #5 clk = ~clk;

    disp_hex_mux_gen_if #(.N_DIG(N_DIG)) bus ();

    disp_hex_mux_gen #(.N_DIG(N_DIG), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t predict(input logic [CNT_W-1:0] q, input logic [1:0] idx,
                                     input logic [15:0] hex, input logic [3:0] dp,
                                     input logic blz, input logic [3:0] br);
        exp_t e;
        logic [15:0] upper;
        logic [3:0]  t;
        upper = hex >> (idx * 4);
        t     = q[CNT_W-1 -: 4];
        e.an   = 4'hF;
        e.sseg = 8'hFF;
        if (!PWM || t <= br) begin
            e.an   = ~(4'b0001 << idx);
            e.sseg = {~dp[idx], (blz && idx != 2'd0 && upper == 16'h0) ? 7'h7F : segTable[upper[3:0]]};
        end
        return e;
    endfunction

    // Reference model: predicts the registered outputs each edge from pre-edge state
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mQ   <= '0;
            mIdx <= '0;
            mHex <= '0;
            mDp  <= '0;
            expQ.delete();
        end else begin
            expQ.push_back(predict(mQ, mIdx, mHex, mDp, bus.blank_lz, bus.bright));
            if (bus.load) begin
                mHex <= bus.hex_in;
                mDp  <= bus.dp_in;
            end
            mQ <= mQ + 1'b1;
            if (mQ == '1)
                mIdx <= mIdx + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("rst_an", {4'h0, bus.an}, 8'h0F);
            checkOutput("rst_sseg", bus.sseg, 8'hFF);
        end else if (expQ.size() > 0) begin
            checkOutput("sb_an", {4'h0, bus.an}, {4'h0, expQ[0].an});
            checkOutput("sb_sseg", bus.sseg, expQ[0].sseg);
            void'(expQ.pop_front());
        end
    end

    task automatic applyStimulus(input logic [15:0] hex, input logic [3:0] dp,
                                 input logic blz, input logic [3:0] br);
        @(negedge clk);
        bus.hex_in   = hex;
        bus.dp_in    = dp;
        bus.blank_lz = blz;
        bus.bright   = br;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic checkDigit(input string tag, input logic [3:0] anVal, input logic [7:0] want);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.an == anVal)
                found = 1'b1;
        end
        if (!found)
            checkOutput({tag, "_timeout"}, {4'h0, bus.an}, {4'h0, anVal});
        else
            checkOutput(tag, bus.sseg, want);
    endtask

    task automatic checkDuty(input string tag, input logic [3:0] br);
        int cnt [4];
        @(negedge clk);
        bus.bright = br;
        @(negedge clk);
        for (int d = 0; d < 4; d++)
            cnt[d] = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++)
                if (bus.an[d] == 1'b0)
                    cnt[d]++;
        end
        for (int d = 0; d < 4; d++)
            checkOutput($sformatf("%s_dig%0d", tag, d), 8'(cnt[d]), PWM ? 8'(br) + 8'd1 : 8'd16);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n      = 1'b1;
        bus.load     = 1'b0;
        bus.hex_in   = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;
        bus.bright   = 4'd15;
        #1 reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_an", {4'h0, bus.an}, 8'h0F);
        checkOutput("reset_sseg", bus.sseg, 8'hFF);

        #2 reset_n = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k % 16 == 1)
                checkOutput($sformatf("scan_%0d", k), {4'h0, bus.an}, {4'h0, scanOrder[k/16]});
        end

        applyStimulus(16'h1234, 4'b0100, 1'b0, 4'd15);
        checkDigit("dec1_d0", 4'hE, 8'h99);
        checkDigit("dec1_d1", 4'hD, 8'hB0);
        checkDigit("dec1_d2", 4'hB, 8'h24);
        checkDigit("dec1_d3", 4'h7, 8'hF9);

        applyStimulus(16'hFEDC, 4'b0000, 1'b0, 4'd15);
        checkDigit("dec2_d0", 4'hE, 8'hC6);
        checkDigit("dec2_d1", 4'hD, 8'hA1);
        checkDigit("dec2_d2", 4'hB, 8'h86);
        checkDigit("dec2_d3", 4'h7, 8'h8E);

        applyStimulus(16'h0050, 4'b0000, 1'b1, 4'd15);
        checkDigit("blz_d3", 4'h7, 8'hFF);
        checkDigit("blz_d2", 4'hB, 8'hFF);
        checkDigit("blz_d1", 4'hD, 8'h92);
        checkDigit("blz_d0", 4'hE, 8'hC0);

        applyStimulus(16'h0000, 4'b0000, 1'b1, 4'd15);
        checkDigit("blz0_d0", 4'hE, 8'hC0);
        checkDigit("blz0_d1", 4'hD, 8'hFF);
        checkDigit("blz0_d2", 4'hB, 8'hFF);
        checkDigit("blz0_d3", 4'h7, 8'hFF);

        applyStimulus(16'h1234, 4'b0100, 1'b0, 4'd15);
        checkDuty("pwm3", 4'd3);
        checkDuty("pwm0", 4'd0);
        checkDuty("pwm15", 4'd15);

        checkDigit("mid_pre", 4'hB, 8'h24);
        bus.hex_in = 16'h0900;
        bus.dp_in  = 4'b0000;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        checkOutput("mid_old", bus.sseg, 8'h24);
        @(negedge clk);
        checkOutput("mid_new", bus.sseg, 8'h90);
        checkOutput("mid_an", {4'h0, bus.an}, 8'h0B);

        checkDigit("rstmid_pre", 4'hB, 8'h90);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstmid_an", {4'h0, bus.an}, 8'h0F);
        checkOutput("rstmid_sseg", bus.sseg, 8'hFF);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_an0", {4'h0, bus.an}, 8'h0E);
        checkOutput("restart_sseg0", bus.sseg, 8'hC0);
        repeat (16) @(negedge clk);
        checkOutput("restart_an1", {4'h0, bus.an}, 8'h0D);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
